// File: rtl/mdio_pkg.sv
// mdio_pkg: frame field codes, FSM encoding and op decode shared by the MDIO master.
package mdio_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;
  localparam logic [1:0] ST_C22    = 2'b01;
  localparam logic [1:0] ST_C45    = 2'b00;
  localparam logic [1:0] OP_ADDR   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_PRIA   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;
  localparam logic [1:0] OP_C22_RD = 2'b10;
  localparam logic [1:0] TA_WRITE  = 2'b10;
  localparam logic [5:0] HDR_BITS  = 6'd14;
  localparam logic [5:0] TA_BITS   = 6'd2;
  localparam logic [5:0] DATA_BITS = 6'd16;
  function automatic logic op_legal(input logic c45, input logic [1:0] op);
    return c45 || op == OP_WRITE || op == OP_C22_RD;
  endfunction
  function automatic logic op_read(input logic c45, input logic [1:0] op);
    return c45 ? (op == OP_READ || op == OP_PRIA) : op == OP_C22_RD;
  endfunction
endpackage

// File: rtl/mdio_clkgen.sv
// mdio_clkgen: MDC divider with one-cycle rise/fall strobes; idles low while disabled.
module mdio_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             mdc_o,
  output logic             rise_o,
  output logic             fall_o
);
  logic [DIV_W-1:0] cnt_q;
  logic             mdc_q;
  logic             wrap;
  assign wrap   = en_i && cnt_q == div_i - DIV_W'(1);
  assign mdc_o  = mdc_q;
  assign rise_o = wrap && !mdc_q;
  assign fall_o = wrap && mdc_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + DIV_W'(1);
      mdc_q <= mdc_q ^ wrap;
    end
  end
endmodule

// File: rtl/mdio_multi_master.sv
// mdio_multi_master: one Clause 22/45 MDIO frame per accepted command, with
// runtime MDC divider, optional preamble and no-PHY-response detection.
module mdio_multi_master
  import mdio_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int PRE_LEN = 32
) (
  input  logic             mgmt_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_clk_div,
  input  logic             cfg_no_pre,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_c45,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_prtad,
  input  logic [4:0]       cmd_devad,
  input  logic [15:0]      cmd_data,
  output logic             rsp_valid,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic             mdc,
  output logic             mdio_o,
  output logic             mdio_t,
  input  logic             mdio_i
);
  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rsp_data_q;
  logic [DIV_W-1:0] div_q;
  logic             rd_q, rd_d, err_q, mdo_q, mdo_d, mdt_q, mdt_d;
  logic             acc, en, rise, fall;

  assign acc = cmd_valid && cmd_ready;

  mdio_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i (mgmt_clk),
    .rst_i (reset),
    .en_i  (en),
    .div_i (div_q),
    .mdc_o (mdc),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_ff @(posedge mgmt_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = !op_legal(cmd_c45, cmd_op) ? S_DONE : cfg_no_pre ? S_HDR : S_PRE;
        cnt_d   = cfg_no_pre ? HDR_BITS - 6'd1 : 6'(PRE_LEN - 1);
      end
      S_DONE: state_d = S_IDLE;
      default: if (fall) begin
        state_d = cnt_q != '0 ? state_q : state_q == S_PRE ? S_HDR :
                  state_q == S_HDR ? S_TA : state_q == S_TA ? S_DATA : S_DONE;
        cnt_d   = cnt_q != '0 ? cnt_q - 6'd1 : state_q == S_PRE ? HDR_BITS - 6'd1 :
                  state_q == S_HDR ? TA_BITS - 6'd1 : DATA_BITS - 6'd1;
      end
    endcase
  end

  always_comb begin
    en        = state_q inside {S_PRE, S_HDR, S_TA, S_DATA};
    cmd_ready = state_q == S_IDLE;
    rsp_valid = state_q == S_DONE;
    rsp_err   = rsp_valid && err_q;
  end

  // The preamble leaves the shift register untouched, so HDR starts on tx_q[31].
  always_comb begin
    rd_d  = acc ? op_read(cmd_c45, cmd_op) : rd_q;
    tx_d  = acc ? {cmd_c45 ? ST_C45 : ST_C22, cmd_op, cmd_prtad, cmd_devad, TA_WRITE, cmd_data} :
            fall && state_q != S_PRE ? {tx_q[30:0], 1'b0} : tx_q;
    mdt_d = state_d inside {S_IDLE, S_DONE} || (rd_d && state_d inside {S_TA, S_DATA});
    mdo_d = mdt_d || state_d == S_PRE || tx_d[31];
  end

  always_ff @(posedge mgmt_clk or posedge reset) begin
    if (reset) begin
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      div_q      <= DIV_W'(1);
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      mdo_q      <= 1'b1;
      mdt_q      <= 1'b1;
    end else begin
      tx_q  <= tx_d;
      rd_q  <= rd_d;
      mdo_q <= mdo_d;
      mdt_q <= mdt_d;
      if (acc) begin
        div_q      <= cfg_clk_div == '0 ? DIV_W'(1) : cfg_clk_div;
        err_q      <= !op_legal(cmd_c45, cmd_op);
        rsp_data_q <= '0;
      end
      if (rise && state_q == S_DATA) rx_q <= {rx_q[14:0], mdio_i};
      if (rise && state_q == S_TA && cnt_q == '0 && rd_q) err_q <= mdio_i;
      if (fall && state_d == S_DONE) rsp_data_q <= rd_q ? rx_q : '0;
    end
  end

  assign rsp_data = rsp_data_q;
  assign mdio_o   = mdo_q;
  assign mdio_t   = mdt_q;
endmodule

// File: tb/tb_mdio_multi_master.sv
// tb_mdio_multi_master: scoreboard bench; expected responses and frames queued at
// command issue, compared when rsp_valid appears. Accept cycle counts as cycle 1.
module tb_mdio_multi_master;
  logic        mgmt_clk = 1'b0;
  logic        reset;
  logic [7:0]  cfg_clk_div;
  logic        cfg_no_pre, cmd_valid, cmd_ready, cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_prtad, cmd_devad;
  logic [15:0] cmd_data, rsp_data;
  logic        rsp_valid, rsp_err, mdc, mdio_o, mdio_t, mdio_i;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          nbits;
    logic [63:0] fr;
    logic [63:0] tm;
  } exp_t;
  exp_t sb[$];

  mdio_multi_master #(.DIV_W(8), .PRE_LEN(32)) dut (
    .mgmt_clk(mgmt_clk), .reset(reset), .cfg_clk_div(cfg_clk_div), .cfg_no_pre(cfg_no_pre),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_c45(cmd_c45), .cmd_op(cmd_op),
    .cmd_prtad(cmd_prtad), .cmd_devad(cmd_devad), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic phy_bit(input int k, input int hs, input logic [15:0] pd, input logic present);
    if (!present) return 1'b1;
    if (k == hs + 15) return 1'b0;
    if (k >= hs + 16 && k < hs + 32) return pd[15 - (k - hs - 16)];
    return 1'b1;
  endfunction

  task automatic run_cmd(input logic c45, input logic [1:0] op, input logic [4:0] prtad,
                         input logic [4:0] devad, input logic [15:0] data, input logic [7:0] div,
                         input logic nopre, input logic present, input logic [15:0] pd,
                         input int abort_at);
    exp_t        e;
    int          d, hs, nr, cyc;
    logic [63:0] cap_o, cap_t, mask;
    logic [31:0] w;
    logic        legal, rd, prev, got;
    d     = div == 0 ? 1 : int'(div);
    legal = c45 || op == 2'b01 || op == 2'b10;
    rd    = c45 ? (op == 2'b11 || op == 2'b10) : op == 2'b10;
    hs    = nopre ? 0 : 32;
    w     = {c45 ? 2'b00 : 2'b01, op, prtad, devad, 2'b10, data};
    e.nbits = legal ? hs + 32 : 0;
    e.fr    = nopre ? {w, 32'h0} : {32'hFFFF_FFFF, w};
    e.tm    = '0;
    if (legal && rd) for (int k = hs + 14; k < hs + 32; k++) e.tm[63 - k] = 1'b1;
    e.err   = !legal || (rd && !present);
    e.data  = (!legal || !rd) ? 16'h0 : present ? pd : 16'hFFFF;
    e.lat   = 2 * d * e.nbits + 2;
    if (abort_at == 0) sb.push_back(e);
    @(negedge mgmt_clk);
    cfg_clk_div = div; cfg_no_pre = nopre; cmd_c45 = c45; cmd_op = op;
    cmd_prtad = prtad; cmd_devad = devad; cmd_data = data; cmd_valid = 1'b1;
    mdio_i = phy_bit(0, hs, pd, present);
    check("ready_before_accept", 64'(cmd_ready), 64'd1);
    cyc = 1; nr = 0; prev = 1'b0; cap_o = '0; cap_t = '0; got = 1'b0;
    while (!got && cyc < 20000) begin
      @(negedge mgmt_clk);
      cyc++;
      cmd_valid = e.nbits > 0 && cyc >= 5 && cyc <= 7;
      cmd_data  = ~data;
      if (cyc == 2 && e.nbits > 0) check("busy_not_ready", 64'(cmd_ready), 64'd0);
      if (mdc && !prev) begin
        if (nr < 64) begin cap_o[63 - nr] = mdio_o; cap_t[63 - nr] = mdio_t; end
        nr++;
      end
      prev   = mdc;
      mdio_i = phy_bit(nr, hs, pd, present);
      if (abort_at > 0 && nr == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_mdc", 64'(mdc), 64'd0);
        check("abort_mdio_t", 64'(mdio_t), 64'd1);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        @(negedge mgmt_clk);
        reset = 1'b0;
        for (int i = 0; i < 16 * d; i++) begin
          @(negedge mgmt_clk);
          if (rsp_valid) got = 1'b1;
        end
        check("abort_no_rsp", 64'(got), 64'd0);
        return;
      end
      if (rsp_valid) begin
        got  = 1'b1;
        e    = sb.pop_front();
        mask = e.nbits == 0 ? 64'h0 : ~64'h0 << (64 - e.nbits);
        check("latency", 64'(cyc), 64'(e.lat));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("mdc_rises", 64'(nr), 64'(e.nbits));
        check("frame_bits", cap_o & mask & ~e.tm, e.fr & mask & ~e.tm);
        check("mdio_t_bits", cap_t, e.tm);
        check("done_released", {62'h0, mdio_o, mdio_t}, 64'h3);
        check("done_not_ready", 64'(cmd_ready), 64'd0);
        @(negedge mgmt_clk);
        check("ready_after", 64'(cmd_ready), 64'd1);
        check("rsp_pulse", 64'(rsp_valid), 64'd0);
      end
    end
    if (!got && abort_at == 0) begin
      check("timeout", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; cfg_clk_div = 8'd1; cfg_no_pre = 1'b0; cmd_valid = 1'b0; cmd_c45 = 1'b0;
    cmd_op = 2'b00; cmd_prtad = '0; cmd_devad = '0; cmd_data = '0; mdio_i = 1'b1;
    repeat (3) @(negedge mgmt_clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio", {62'h0, mdio_o, mdio_t}, 64'h3);
    reset = 1'b0;
    @(negedge mgmt_clk);
    run_cmd(1'b0, 2'b01, 5'h01, 5'h00, 16'h1234, 8'd2, 1'b0, 1'b1, 16'h0, 0);
    run_cmd(1'b1, 2'b11, 5'h03, 5'h1E, 16'h0000, 8'd4, 1'b1, 1'b1, 16'hBEEF, 0);
    run_cmd(1'b1, 2'b11, 5'h07, 5'h01, 16'h0000, 8'd1, 1'b0, 1'b0, 16'h0, 0);
    run_cmd(1'b0, 2'b11, 5'h02, 5'h04, 16'hAAAA, 8'd3, 1'b0, 1'b1, 16'h0, 0);
    run_cmd(1'b0, 2'b00, 5'h02, 5'h04, 16'h5555, 8'd3, 1'b0, 1'b1, 16'h0, 0);
    run_cmd(1'b0, 2'b10, 5'h1F, 5'h11, 16'h0000, 8'd0, 1'b0, 1'b1, 16'h5A5A, 0);
    run_cmd(1'b1, 2'b00, 5'h15, 5'h0A, 16'hC3A5, 8'd3, 1'b1, 1'b1, 16'h0, 0);
    run_cmd(1'b1, 2'b10, 5'h0C, 5'h03, 16'h0000, 8'd1, 1'b1, 1'b1, 16'h0001, 0);
    run_cmd(1'b0, 2'b01, 5'h09, 5'h12, 16'hFACE, 8'd2, 1'b0, 1'b1, 16'h0, 20);
    run_cmd(1'b0, 2'b01, 5'h09, 5'h12, 16'hFACE, 8'd2, 1'b0, 1'b1, 16'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
